// File: rtl/debug_tx_sequencer_pkg.sv
// Shared debugger definitions: sequencer state encoding, frame header byte
// and snapshot geometry used by the debugger blocks.
package debug_tx_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_FETCH,
        ST_LOAD,
        ST_SEND,
        ST_GAP,
        ST_CHECKSUM,
        ST_DONE
    } state_t;

    localparam logic [7:0] DBG_HEADER_BYTE = 8'hA5;
    localparam int         DBG_SNAP_WORDS  = 55;
    localparam int         SNAP_ADDR_W     = 6;

endpackage

// File: rtl/debug_tx_sequencer_if.sv
// Port bundle between the dump sequencer (master) and its environment:
// command FSM, snapshot read port and UART TX FIFO (slave side).
interface debug_tx_sequencer_if;
    import debug_tx_sequencer_pkg::*;

    // Handshake: send_start is a level held until data_sent pulses; a byte is
    // transferred when wr_uart=1 (w_data valid that cycle), and the master only
    // raises wr_uart after sampling tx_full=0 on the preceding clock edge.
    logic                   send_start;
    logic [SNAP_ADDR_W-1:0] snap_addr;
    logic [31:0]            snap_data;
    logic                   tx_full;
    logic                   wr_uart;
    logic [7:0]             w_data;
    logic                   data_sent;
    logic                   busy;

    modport master (
        input  send_start, snap_data, tx_full,
        output snap_addr, wr_uart, w_data, data_sent, busy
    );

    modport slave (
        output send_start, snap_data, tx_full,
        input  snap_addr, wr_uart, w_data, data_sent, busy
    );

endinterface

// File: rtl/debug_tx_sequencer.sv
// Streams a snapshot dump to the UART TX FIFO as one frame:
// header, payload bytes (word 0 first, MSB byte first), XOR checksum.
module debug_tx_sequencer
    import debug_tx_sequencer_pkg::*;
#(
    parameter int         NUM_WORDS   = DBG_SNAP_WORDS,
    parameter logic [7:0] HEADER_BYTE = DBG_HEADER_BYTE
) (
    input  logic                 clock,
    input  logic                 reset,
    debug_tx_sequencer_if.master bus,
    output state_t               dbg_state
);

    localparam logic [SNAP_ADDR_W-1:0] LAST_WORD = SNAP_ADDR_W'(NUM_WORDS - 1);

    state_t      state;
    state_t      gap_next;
    logic        advance;
    logic        armed;
    logic [31:0] shift_reg;
    logic [1:0]  byte_cnt;
    logic [7:0]  checksum;

    assign dbg_state = state;

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_IDLE;
            gap_next      <= ST_IDLE;
            advance       <= 1'b0;
            armed         <= 1'b1;
            shift_reg     <= '0;
            byte_cnt      <= '0;
            checksum      <= '0;
            bus.snap_addr <= '0;
            bus.wr_uart   <= 1'b0;
            bus.w_data    <= '0;
            bus.data_sent <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            bus.wr_uart   <= 1'b0;
            bus.data_sent <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // armed re-arms only after send_start is seen low, so a
                    // level held past DONE cannot retrigger a second frame
                    if (bus.send_start && armed) begin
                        state         <= ST_HEADER;
                        armed         <= 1'b0;
                        checksum      <= '0;
                        byte_cnt      <= '0;
                        bus.snap_addr <= '0;
                        bus.busy      <= 1'b1;
                    end else if (!bus.send_start) begin
                        armed <= 1'b1;
                    end
                end
                ST_HEADER: begin
                    if (!bus.tx_full) begin
                        bus.wr_uart <= 1'b1;
                        bus.w_data  <= HEADER_BYTE;
                        gap_next    <= ST_FETCH;
                        advance     <= 1'b0;
                        state       <= ST_GAP;
                    end
                end
                ST_FETCH: begin
                    state <= ST_LOAD;
                end
                ST_LOAD: begin
                    shift_reg <= bus.snap_data;
                    byte_cnt  <= '0;
                    state     <= ST_SEND;
                end
                ST_SEND: begin
                    if (!bus.tx_full) begin
                        bus.wr_uart <= 1'b1;
                        bus.w_data  <= shift_reg[31:24];
                        shift_reg   <= {shift_reg[23:0], 8'h00};
                        checksum    <= checksum ^ shift_reg[31:24];
                        byte_cnt    <= byte_cnt + 2'd1;
                        state       <= ST_GAP;
                        if (byte_cnt != 2'd3) begin
                            gap_next <= ST_SEND;
                            advance  <= 1'b0;
                        end else if (bus.snap_addr == LAST_WORD) begin
                            gap_next <= ST_CHECKSUM;
                            advance  <= 1'b0;
                        end else begin
                            gap_next <= ST_FETCH;
                            advance  <= 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    // the word index moves here so it is stable throughout FETCH
                    state <= gap_next;
                    if (advance) begin
                        bus.snap_addr <= bus.snap_addr + 1'b1;
                    end
                    if (gap_next == ST_DONE) begin
                        bus.data_sent <= 1'b1;
                    end
                end
                ST_CHECKSUM: begin
                    if (!bus.tx_full) begin
                        bus.wr_uart <= 1'b1;
                        bus.w_data  <= checksum;
                        gap_next    <= ST_DONE;
                        advance     <= 1'b0;
                        state       <= ST_GAP;
                    end
                end
                ST_DONE: begin
                    state    <= ST_IDLE;
                    bus.busy <= 1'b0;
                end
                default: begin
                    state    <= ST_IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debug_tx_sequencer.sv
// Bench for debug_tx_sequencer: a 2-word and a 55-word instance driven with
// directed and randomized frames, scored against a frame-level reference.
module tb_debug_tx_sequencer;
    import debug_tx_sequencer_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    debug_tx_sequencer_if if_a ();
    debug_tx_sequencer_if if_b ();
    state_t dbg_a;
    state_t dbg_b;

    debug_tx_sequencer #(.NUM_WORDS(2)) dut_a (
        .clock(clock), .reset(reset), .bus(if_a.master), .dbg_state(dbg_a)
    );
    debug_tx_sequencer #(.NUM_WORDS(55)) dut_b (
        .clock(clock), .reset(reset), .bus(if_b.master), .dbg_state(dbg_b)
    );

    // Snapshot memories with one-cycle registered read
    logic [31:0] mem_a [0:1];
    logic [31:0] mem_b [0:63];

    always @(posedge clock) begin
        if_a.snap_data <= mem_a[if_a.snap_addr[0]];
        if_b.snap_data <= mem_b[if_b.snap_addr];
    end

    // Scoreboard state
    logic [7:0] exp_q[$];
    logic [7:0] got_a[$];
    logic [7:0] got_b[$];
    logic [5:0] addr_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int sent_a, sent_b, gap_viol_a, gap_viol_b, full_viol_a, full_viol_b;
    int busy_cyc_a, busy_cyc_b;
    int last_wr_a = -10;
    int last_wr_b = -10;
    logic full_prev_a = 1'b0;
    logic full_prev_b = 1'b0;
    logic [5:0] prev_addr_b = '0;

    always @(negedge clock) begin
        cyc++;
        if (if_a.wr_uart) begin
            got_a.push_back(if_a.w_data);
            if (cyc - last_wr_a < 2) gap_viol_a++;
            if (full_prev_a) full_viol_a++;
            last_wr_a = cyc;
        end
        if (if_b.wr_uart) begin
            got_b.push_back(if_b.w_data);
            if (cyc - last_wr_b < 2) gap_viol_b++;
            if (full_prev_b) full_viol_b++;
            last_wr_b = cyc;
        end
        if (if_a.data_sent) sent_a++;
        if (if_b.data_sent) sent_b++;
        if (if_a.busy) busy_cyc_a++;
        if (if_b.busy) busy_cyc_b++;
        if (if_b.snap_addr != prev_addr_b) begin
            addr_q.push_back(if_b.snap_addr);
            prev_addr_b = if_b.snap_addr;
        end
        full_prev_a = if_a.tx_full;
        full_prev_b = if_b.tx_full;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not complete");
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        got_a.delete(); got_b.delete(); addr_q.delete();
        sent_a = 0; sent_b = 0;
        gap_viol_a = 0; gap_viol_b = 0;
        full_viol_a = 0; full_viol_b = 0;
        busy_cyc_a = 0; busy_cyc_b = 0;
    endtask

    // Reference frame: header, words MSB byte first, XOR of payload bytes
    task automatic build_exp(input logic [31:0] words[$]);
        logic [7:0] x;
        logic [7:0] b;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        x = 8'h00;
        foreach (words[i]) begin
            for (int k = 3; k >= 0; k--) begin
                b = words[i][8*k +: 8];
                exp_q.push_back(b);
                x = x ^ b;
            end
        end
        exp_q.push_back(x);
    endtask

    task automatic score(input string tag, input logic [7:0] got[$]);
        chk({tag, "_len"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
    endtask

    task automatic drive(input int w, input logic st, input logic full);
        if (w == 0) begin
            if_a.send_start = st; if_a.tx_full = full;
        end else begin
            if_b.send_start = st; if_b.tx_full = full;
        end
    endtask

    function automatic int sent_of(input int w);
        return (w == 0) ? sent_a : sent_b;
    endfunction

    function automatic int got_size(input int w);
        return (w == 0) ? got_a.size() : got_b.size();
    endfunction

    // full_mode: <0 = tx_full high on cycles 3..12, else percent chance per cycle
    task automatic run_frame(input int w, input string tag, input int full_mode,
                             input int drop_after, input int nwords);
        int n;
        int budget;
        logic start;
        logic full;
        budget = 60 * nwords + 400;
        drive(w, 1'b0, 1'b0);
        tick(2);
        clear_mon();
        start = 1'b1;
        n = 0;
        while (sent_of(w) == 0 && n < budget) begin
            if (full_mode < 0) full = (n >= 3 && n <= 12);
            else full = ($urandom_range(0, 99) < full_mode);
            if (drop_after >= 0 && got_size(w) >= drop_after) start = 1'b0;
            drive(w, start, full);
            tick(1);
            n++;
        end
        drive(w, start, 1'b0);
        chk({tag, "_done"}, 32'(sent_of(w)), 32'd1);
        tick(40);
        chk({tag, "_one_pulse"}, 32'(sent_of(w)), 32'd1);
        if (w == 0) begin
            chk({tag, "_gap"}, 32'(gap_viol_a), 32'd0);
            chk({tag, "_full"}, 32'(full_viol_a), 32'd0);
            chk({tag, "_busy_end"}, 32'(if_a.busy), 32'd0);
            if (full_mode == 0 && drop_after < 0)
                chk({tag, "_busy_cycles"}, 32'(busy_cyc_a), 32'(10 * nwords + 5));
            score(tag, got_a);
        end else begin
            chk({tag, "_gap"}, 32'(gap_viol_b), 32'd0);
            chk({tag, "_full"}, 32'(full_viol_b), 32'd0);
            chk({tag, "_busy_end"}, 32'(if_b.busy), 32'd0);
            if (full_mode == 0 && drop_after < 0)
                chk({tag, "_busy_cycles"}, 32'(busy_cyc_b), 32'(10 * nwords + 5));
            score(tag, got_b);
        end
    endtask

    initial begin
        logic [31:0] words[$];
        int n;

        drive(0, 1'b0, 1'b0);
        drive(1, 1'b0, 1'b0);
        mem_a[0] = 32'h11223344;
        mem_a[1] = 32'hAABBCCDD;
        for (int i = 0; i < 64; i++) mem_b[i] = 32'h01010101;

        // Reset values, sampled while reset is still asserted
        tick(3);
        chk("rst_wr_uart",   32'(if_a.wr_uart),   32'd0);
        chk("rst_w_data",    32'(if_a.w_data),    32'd0);
        chk("rst_data_sent", 32'(if_a.data_sent), 32'd0);
        chk("rst_busy",      32'(if_a.busy),      32'd0);
        chk("rst_snap_addr", 32'(if_a.snap_addr), 32'd0);
        chk("rst_state",     32'(dbg_a),          32'(ST_IDLE));
        reset = 1'b0;
        tick(2);

        // Directed two-word frame, no back-pressure, start held high
        words = '{32'h11223344, 32'hAABBCCDD};
        build_exp(words);
        run_frame(0, "basic", 0, -1, 2);

        // Same frame, FIFO full for a window; re-armed by the low pulse
        run_frame(0, "stall", -1, -1, 2);

        // Reset after the fifth byte abandons the frame
        drive(0, 1'b0, 1'b0);
        tick(2);
        clear_mon();
        drive(0, 1'b1, 1'b0);
        n = 0;
        while (got_a.size() < 5 && n < 200) begin
            tick(1);
            n++;
        end
        chk("rstmid_reach5", 32'(got_a.size()), 32'd5);
        reset = 1'b1;
        drive(0, 1'b0, 1'b0);
        tick(1);
        chk("rstmid_busy",  32'(if_a.busy),    32'd0);
        chk("rstmid_wr",    32'(if_a.wr_uart), 32'd0);
        chk("rstmid_state", 32'(dbg_a),        32'(ST_IDLE));
        tick(1);
        reset = 1'b0;
        tick(30);
        chk("rstmid_no_more_wr", 32'(got_a.size()), 32'd5);
        chk("rstmid_no_sent",    32'(sent_a),        32'd0);
        run_frame(0, "after_rst", 0, -1, 2);

        // Random payloads and back-pressure, start dropped mid-payload
        for (int t = 0; t < 3; t++) begin
            mem_a[0] = $urandom;
            mem_a[1] = $urandom;
            words = '{mem_a[0], mem_a[1]};
            build_exp(words);
            run_frame(0, $sformatf("drop%0d", t), 30, 3 + t, 2);
        end

        // Full-size dump of 0x01010101 words: checksum 0x00, address sweep
        words.delete();
        for (int i = 0; i < 55; i++) words.push_back(mem_b[i]);
        build_exp(words);
        run_frame(1, "big", 0, -1, 55);
        chk("big_writes", 32'(exp_q.size()), 32'(got_b.size()));
        chk("big_addr_steps", 32'(addr_q.size()), 32'd54);
        for (int i = 0; i < addr_q.size(); i++)
            chk($sformatf("big_addr%0d", i + 1), 32'(addr_q[i]), 32'(i + 1));
        chk("big_addr_final", 32'(if_b.snap_addr), 32'd54);

        // Full-size dump with random contents and random back-pressure
        words.delete();
        for (int i = 0; i < 55; i++) begin
            mem_b[i] = $urandom;
            words.push_back(mem_b[i]);
        end
        build_exp(words);
        run_frame(1, "big_rand", 25, -1, 55);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
